// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared state type and default parameters for the USB TX bit timer
package usb_tx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_DIV_W         = 4;
  localparam int DEF_BYTE_W        = 7;
  localparam int DEF_BITS_PER_BYTE = 8;

endpackage

// File: rtl/usb_tx_flex_counter.sv
// rtl/usb_tx_flex_counter.sv - N-bit up counter with sync clear and programmable rollover
module usb_tx_flex_counter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         count_enable,
  input  logic [N-1:0] rollover_val,
  output logic [N-1:0] count_out
);

  logic [N-1:0] r_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count_enable) begin
      if (r_count == rollover_val) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign count_out = r_count;

endmodule

// File: rtl/usb_tx_timer.sv
// rtl/usb_tx_timer.sv - bit/byte/packet timing for a USB transmitter
module usb_tx_timer
  import usb_tx_pkg::*;
#(
  parameter int DIV_W         = DEF_DIV_W,
  parameter int BYTE_W        = DEF_BYTE_W,
  parameter int BITS_PER_BYTE = DEF_BITS_PER_BYTE
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              start,
  input  logic              stall,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [BYTE_W-1:0] num_bytes,
  output logic              busy,
  output logic              bit_strobe,
  output logic              byte_done,
  output logic              packet_done,
  output logic [3:0]        bit_cnt,
  output logic [BYTE_W-1:0] byte_cnt
);

  state_t            r_state;
  state_t            w_next_state;
  logic [DIV_W-1:0]  r_clk_div;
  logic [BYTE_W-1:0] r_num_bytes;
  logic [DIV_W-1:0]  w_div_cnt;
  logic [DIV_W-1:0]  w_div_last;
  logic [3:0]        w_bit_last;
  logic [BYTE_W-1:0] w_byte_last;
  logic              w_run;
  logic              w_accept;
  logic              w_cnt_clear;

  assign w_run    = (r_state == RUN);
  assign w_accept = !w_run && start && (num_bytes != '0) && !clear;

  // Divide ratios 0 and 1 both collapse to a single-clock bit period.
  assign w_div_last  = (r_clk_div > DIV_W'(1)) ? (r_clk_div - DIV_W'(1)) : '0;
  assign w_bit_last  = 4'(BITS_PER_BYTE - 1);
  assign w_byte_last = r_num_bytes - 1'b1;

  assign busy        = w_run;
  assign bit_strobe  = w_run && (w_div_cnt == w_div_last);
  assign byte_done   = bit_strobe && !stall && (bit_cnt == w_bit_last);
  assign packet_done = byte_done && (byte_cnt == w_byte_last);

  // Counters sit at zero whenever not running, and zero on abort or packet end.
  assign w_cnt_clear = clear || !w_run || packet_done;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_clk_div   <= '0;
      r_num_bytes <= '0;
    end else if (w_accept) begin
      r_clk_div   <= clk_div;
      r_num_bytes <= num_bytes;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_next_state = RUN;
        RUN:     if (packet_done) w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  usb_tx_flex_counter #(.N(DIV_W)) u_div_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (w_cnt_clear),
    .count_enable (w_run),
    .rollover_val (w_div_last),
    .count_out    (w_div_cnt)
  );

  usb_tx_flex_counter #(.N(4)) u_bit_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (w_cnt_clear),
    .count_enable (bit_strobe && !stall),
    .rollover_val (w_bit_last),
    .count_out    (bit_cnt)
  );

  usb_tx_flex_counter #(.N(BYTE_W)) u_byte_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (w_cnt_clear),
    .count_enable (byte_done),
    .rollover_val (w_byte_last),
    .count_out    (byte_cnt)
  );

endmodule
